// File: rtl/data_cache_if.sv
// CPU request/response and data-memory bus bundle for data_cache.
// The slave modport is the cache side; the master modport is the CPU/memory side.
interface data_cache_if;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_dout;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, mem_dout,
        output req_ready, resp_valid, resp_rdata, mem_addr, mem_din, mem_read, mem_write
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, mem_dout,
        input  req_ready, resp_valid, resp_rdata, mem_addr, mem_din, mem_read, mem_write
    );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-back/write-allocate data cache with 4-word blocks.
// Optional hit/miss statistics outputs are enabled by defining DCACHE_STATS_EN.
module data_cache #(
    parameter int MEM_LATENCY = 2,
    parameter int NUM_SETS    = 16
) (
    input  logic          clk,
    input  logic          reset,
    data_cache_if.slave   bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]   hit_count,
    output logic [31:0]   miss_count
`endif
);
    localparam int         IDX_W    = $clog2(NUM_SETS);
    localparam int         TAG_W    = 28 - IDX_W;
    localparam logic [3:0] LAT_LAST = 4'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

    state_t              state_q, state_d;
    logic [1:0]          beat_q, beat_d;
    logic [3:0]          lat_q, lat_d;
    logic                write_q, write_d;
    logic [29:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [NUM_SETS-1:0] valid_q, valid_d;
    logic [NUM_SETS-1:0] dirty_q, dirty_d;

    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    logic [31:0]         data_q [NUM_SETS][4];

`ifdef DCACHE_STATS_EN
    logic                first_q, first_d;
    logic [31:0]         hit_count_q, hit_count_d;
    logic [31:0]         miss_count_q, miss_count_d;

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

    logic [1:0]          off;
    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    req_tag;
    logic [TAG_W-1:0]    line_tag;
    logic                hit;
    logic                lat_last;

    logic                data_we;
    logic [1:0]          data_word;
    logic [31:0]         data_wval;
    logic                tag_we;

    logic                resp_valid;
    logic [31:0]         resp_rdata;
    logic                mem_read;
    logic                mem_write;
    logic [31:0]         mem_addr;
    logic [31:0]         mem_din;

    // addr_q holds the word address; the byte offset bits are dropped at accept
    assign off      = addr_q[1:0];
    assign idx      = addr_q[2 +: IDX_W];
    assign req_tag  = addr_q[29 -: TAG_W];
    assign line_tag = tag_q[idx];
    assign hit      = valid_q[idx] && (line_tag == req_tag);
    assign lat_last = (lat_q == LAT_LAST);

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = resp_valid;
    assign bus.resp_rdata = resp_rdata;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_din    = mem_din;

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        lat_d      = lat_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        data_we    = 1'b0;
        data_word  = off;
        data_wval  = wdata_q;
        tag_we     = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_din    = '0;
`ifdef DCACHE_STATS_EN
        first_d      = first_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    addr_d  = bus.req_addr[31:2];
                    wdata_d = bus.req_wdata;
                    state_d = COMPARE;
`ifdef DCACHE_STATS_EN
                    first_d = 1'b1;
`endif
                end
            end
            COMPARE: begin
`ifdef DCACHE_STATS_EN
                // The post-refill lookup always hits and must not be counted
                if (first_q) begin
                    if (hit) hit_count_d  = hit_count_q + 32'd1;
                    else     miss_count_d = miss_count_q + 32'd1;
                end
                first_d = 1'b0;
`endif
                if (hit) begin
                    resp_valid = 1'b1;
                    state_d    = IDLE;
                    if (write_q) begin
                        data_we      = 1'b1;
                        dirty_d[idx] = 1'b1;
                    end else begin
                        resp_rdata = data_q[idx][off];
                    end
                end else if (dirty_q[idx]) begin
                    state_d = WRITEBACK;
                end else begin
                    state_d = ALLOCATE;
                end
            end
            WRITEBACK: begin
                mem_write = 1'b1;
                mem_addr  = {line_tag, idx, beat_q, 2'b00};
                mem_din   = data_q[idx][beat_q];
                if (lat_last && beat_q == 2'd3) begin
                    dirty_d[idx] = 1'b0;
                    state_d      = ALLOCATE;
                end
            end
            ALLOCATE: begin
                mem_read = 1'b1;
                mem_addr = {req_tag, idx, beat_q, 2'b00};
                // Memory data is taken on the last cycle of each word window
                if (lat_last) begin
                    data_we   = 1'b1;
                    data_word = beat_q;
                    data_wval = bus.mem_dout;
                    if (beat_q == 2'd3) begin
                        valid_d[idx] = 1'b1;
                        dirty_d[idx] = 1'b0;
                        tag_we       = 1'b1;
                        state_d      = COMPARE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q == WRITEBACK || state_q == ALLOCATE) begin
            if (lat_last) begin
                lat_d  = '0;
                beat_d = beat_q + 2'd1;
            end else begin
                lat_d = lat_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        write_q <= write_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            lat_q   <= '0;
            valid_q <= '0;
            dirty_q <= '0;
`ifdef DCACHE_STATS_EN
            first_q      <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
`ifdef DCACHE_STATS_EN
            first_q      <= first_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
`endif
        end
    end

    // Tag and data arrays carry no reset; a cleared valid bit masks them
    always_ff @(posedge clk) begin
        if (data_we) data_q[idx][data_word] <= data_wval;
        if (tag_we)  tag_q[idx] <= req_tag;
    end
endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: table of CPU requests with expected data,
// latency and memory traffic, plus reset-abort and held-request sequences.
module tb_data_cache;
    logic clk = 1'b0;
    logic reset;
    logic preload;

    data_cache_if bus ();

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    data_cache #(.MEM_LATENCY(2), .NUM_SETS(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 clk = ~clk;

    // Backing memory: word i holds 0xA0000000+i, except word 0x40 (byte 0x100)
    logic [31:0] tbmem [4096];
    assign bus.mem_dout = tbmem[bus.mem_addr[13:2]];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 4096; i++)
                tbmem[i] <= (i == 32'h40) ? 32'hDEADBEEF : 32'hA000_0000 + 32'(i);
        end else if (bus.mem_write) begin
            tbmem[bus.mem_addr[13:2]] <= bus.mem_din;
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int exp_hits = 0;
    int exp_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] a_first;
        logic [31:0] a_last;
    } vec_t;

    vec_t vecs [11];

    // Issue one request and follow it until resp_valid (bounded)
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rdata,
                          output int nrd, output int nwr,
                          output logic [31:0] a_first, output logic [31:0] a_last);
        bit seen_strobe;
        lat = -1; rdata = '0; nrd = 0; nwr = 0; a_first = '0; a_last = '0;
        seen_strobe = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        @(posedge clk);
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            if (bus.mem_read && bus.mem_write) chk("strobes_exclusive", 32'd1, 32'd0);
            if (!bus.mem_read && !bus.mem_write && (bus.mem_addr != 0 || bus.mem_din != 0))
                chk("idle_mem_bus_zero", bus.mem_addr | bus.mem_din, 32'd0);
            if (bus.mem_read || bus.mem_write) begin
                if (!seen_strobe) a_first = bus.mem_addr;
                seen_strobe = 1'b1;
                a_last = bus.mem_addr;
                if (bus.mem_read)  nrd++;
                if (bus.mem_write) nwr++;
            end
            if (bus.resp_valid) begin
                lat   = c;
                rdata = bus.resp_rdata;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    int          lat, nrd, nwr, pulses, bad_addr;
    logic [31:0] rdata, a_first, a_last;

    initial begin
        reset         = 1'b1;
        preload       = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        //          wr    addr          wdata         rdata         lat nrd nwr first         last
        vecs[0]  = '{1'b0, 32'h0000_0100, 32'h0,         32'hDEADBEEF, 10, 8, 0, 32'h0000_0100, 32'h0000_010C};
        vecs[1]  = '{1'b0, 32'h0000_0104, 32'h0,         32'hA000_0041, 1, 0, 0, 32'h0,         32'h0};
        vecs[2]  = '{1'b0, 32'h0000_010E, 32'h0,         32'hA000_0043, 1, 0, 0, 32'h0,         32'h0};
        vecs[3]  = '{1'b1, 32'h0000_0100, 32'h12345678, 32'h0,          1, 0, 0, 32'h0,         32'h0};
        vecs[4]  = '{1'b0, 32'h0000_0100, 32'h0,         32'h12345678,  1, 0, 0, 32'h0,         32'h0};
        vecs[5]  = '{1'b0, 32'h0000_1100, 32'h0,         32'hA000_0440, 18, 8, 8, 32'h0000_0100, 32'h0000_110C};
        vecs[6]  = '{1'b0, 32'h0000_1108, 32'h0,         32'hA000_0442, 1, 0, 0, 32'h0,         32'h0};
        vecs[7]  = '{1'b0, 32'h0000_0200, 32'h0,         32'hA000_0080, 10, 8, 0, 32'h0000_0200, 32'h0000_020C};
        vecs[8]  = '{1'b1, 32'h0000_02F0, 32'hCAFEF00D, 32'h0,         10, 8, 0, 32'h0000_02F0, 32'h0000_02FC};
        vecs[9]  = '{1'b0, 32'h0000_02F0, 32'h0,         32'hCAFEF00D,  1, 0, 0, 32'h0,         32'h0};
        vecs[10] = '{1'b0, 32'h0000_03FC, 32'h0,         32'hA000_00FF, 18, 8, 8, 32'h0000_02F0, 32'h0000_03FC};

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset   = 1'b0;
        preload = 1'b0;
        chk("reset_req_ready",  32'(bus.req_ready), 32'd1);
        chk("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("reset_resp_rdata", bus.resp_rdata, 32'd0);
        chk("reset_mem_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        chk("reset_mem_addr",   bus.mem_addr, 32'd0);
`ifdef DCACHE_STATS_EN
        chk("reset_hit_count",  hit_count, 32'd0);
        chk("reset_miss_count", miss_count, 32'd0);
`endif

        for (int v = 0; v < 11; v++) begin
            do_req(vecs[v].wr, vecs[v].addr, vecs[v].wdata, lat, rdata, nrd, nwr, a_first, a_last);
            chk($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].lat));
            if (!vecs[v].wr) chk($sformatf("v%0d_rdata", v), rdata, vecs[v].rdata);
            chk($sformatf("v%0d_mem_reads", v), 32'(nrd), 32'(vecs[v].nrd));
            chk($sformatf("v%0d_mem_writes", v), 32'(nwr), 32'(vecs[v].nwr));
            if (vecs[v].nrd + vecs[v].nwr != 0) begin
                chk($sformatf("v%0d_first_addr", v), a_first, vecs[v].a_first);
                chk($sformatf("v%0d_last_addr", v), a_last, vecs[v].a_last);
            end
            if (vecs[v].lat == 1) exp_hits++;
            else                  exp_miss++;
`ifdef DCACHE_STATS_EN
            chk($sformatf("v%0d_hit_count", v), hit_count, 32'(exp_hits));
            chk($sformatf("v%0d_miss_count", v), miss_count, 32'(exp_miss));
`endif
        end

        // Evicted dirty lines must have reached memory, clean words unchanged
        chk("wb_word_0x100", tbmem[12'h040], 32'h12345678);
        chk("wb_word_0x104", tbmem[12'h041], 32'hA000_0041);
        chk("wb_word_0x2F0", tbmem[12'h0BC], 32'hCAFEF00D);

        // Reset during the third ALLOCATE cycle of a clean miss
        do_reset();
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h0000_0100;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_in_allocate", 32'(bus.mem_read), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_mem_read",   32'(bus.mem_read), 32'd0);
        chk("abort_mem_write",  32'(bus.mem_write), 32'd0);
        chk("abort_req_ready",  32'(bus.req_ready), 32'd1);
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            if (bus.resp_valid) pulses++;
            @(negedge clk);
        end
        chk("abort_no_response", 32'(pulses), 32'd0);
        do_req(1'b0, 32'h0000_0100, 32'h0, lat, rdata, nrd, nwr, a_first, a_last);
        chk("reload_latency", 32'(lat), 32'd10);
        chk("reload_rdata",   rdata, 32'h12345678);
        chk("reload_reads",   32'(nrd), 32'd8);
`ifdef DCACHE_STATS_EN
        chk("reload_miss_count", miss_count, 32'd1);
        chk("reload_hit_count",  hit_count, 32'd0);
`endif

        // Request held with a changing address across a miss
        pulses = 0; bad_addr = 0; lat = -1; rdata = '0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h0000_0400;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            bus.req_addr = 32'h0000_0800 + 32'(c) * 32'd20;
            if (bus.mem_read && (bus.mem_addr < 32'h400 || bus.mem_addr > 32'h40C)) bad_addr++;
            if (bus.resp_valid) begin
                pulses++;
                if (pulses == 1) begin
                    lat   = c;
                    rdata = bus.resp_rdata;
                end
                bus.req_valid = 1'b0;
            end
        end
        chk("held_resp_pulses", 32'(pulses), 32'd1);
        chk("held_latency",     32'(lat), 32'd10);
        chk("held_rdata",       rdata, 32'hA000_0100);
        chk("held_bad_addr",    32'(bad_addr), 32'd0);
`ifdef DCACHE_STATS_EN
        chk("held_miss_count",  miss_count, 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter MEM_LATENCY, default 2: cycles each memory-side word access is held (range 1..15).
REQ-002 Parameter NUM_SETS, default 16: direct-mapped sets, power of two; block = 4 words of 32 bits.
REQ-003 clk  in  1  clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 req_valid  in  1  CPU request present.
REQ-006 req_write  in  1  1 = store, 0 = load.
REQ-007 req_addr  in  32  byte address; bits [1:0] ignored.
REQ-008 req_wdata  in  32  store data.
REQ-009 req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready.
REQ-010 resp_valid  out  1  one-cycle pulse marking completion of the accepted request.
REQ-011 resp_rdata  out  32  load data, valid when resp_valid && load.
REQ-012 mem_addr  out  32  word-aligned byte address to data memory.
REQ-013 mem_din  out  32  write data to data memory.
REQ-014 mem_read / mem_write  out  1 each  memory read/write strobes, never both high.
REQ-015 mem_dout  in  32  asynchronous read data from data memory.

Function
REQ-016 Address split (NUM_SETS=16): offset [3:2], index [7:4], tag [31:8]; widths scale with log2(NUM_SETS).
REQ-017 FSM states: IDLE, COMPARE, WRITEBACK, ALLOCATE.
REQ-018 IDLE: on accept, latch write/addr/wdata, go COMPARE next cycle.
REQ-019 COMPARE hit (valid && tag match): resp_valid=1 this cycle; load returns word; store updates word, sets dirty; next state IDLE.
REQ-020 COMPARE miss: dirty victim -> WRITEBACK, else -> ALLOCATE; resp_valid stays 0.
REQ-021 WRITEBACK: words 0..3 in order, mem_addr={victim_tag,index,k,2'b00}, mem_write=1, each word held MEM_LATENCY cycles; after word 3 clear dirty, go ALLOCATE.
REQ-022 ALLOCATE: words 0..3 in order, mem_read=1, mem_addr={req_tag,index,k,2'b00}; mem_dout captured on last cycle of each word window; after word 3 set valid, write tag, dirty=0, go COMPARE (resolves as hit).
REQ-023 Miss latency = 1 + 4*MEM_LATENCY (clean) or 1 + 8*MEM_LATENCY (dirty) cycles, plus the COMPARE hit cycle.
REQ-024 Write-back, write-allocate; stores never reach memory until eviction.
REQ-025 Outside WRITEBACK/ALLOCATE mem_read=mem_write=0 and mem_addr/mem_din=0.
REQ-026 req_* inputs ignored while req_ready=0; latched copy drives all processing.
REQ-027 Beat counter wraps 3->0 only on state exit; latency counter reloads per word.

Reset
REQ-028 On reset: state IDLE, all valid and dirty bits 0, counters 0, req_ready=1 next cycle, resp_valid=0, resp_rdata=0, mem strobes 0.
REQ-029 Reset mid-WRITEBACK/ALLOCATE aborts immediately; no memory strobe asserted in cycle after reset; no response issued for the aborted request.
REQ-030 Data/tag arrays need no reset; contents unused while valid=0.

Configuration
REQ-031 DCACHE_STATS_EN defined: adds outputs hit_count, miss_count (32 bits each), incremented in COMPARE on first lookup of each request only (post-refill hit not counted), cleared on reset, wrap at 2^32.
REQ-032 DCACHE_STATS_EN undefined: ports and counters absent; other behaviour identical.

Verification
REQ-033 Reset, load 0x100 (mem word 0x100=0xDEADBEEF), MEM_LATENCY=2 -> 4 reads 0x100..0x10C, 2 cycles each, resp_rdata=0xDEADBEEF, miss_count=1.
REQ-034 Load 0x104 after REQ-033 -> resp_valid 1 cycle after accept, no mem strobe, hit_count=1.
REQ-035 Store 0x100=0x12345678, then load 0x1100 (same index 0) -> writeback 0x100..0x10C with 0x12345678 at 0x100, then allocate 0x1100..0x110C.
REQ-036 Reset asserted on 3rd cycle of ALLOCATE -> strobes 0 next cycle, req_ready=1, reload 0x100 misses again.
REQ-037 req_valid held with changing req_addr during miss -> only first address serviced; single resp_valid pulse.
